// File: rtl/sma_sched.sv
// Round-robin scheduler sharing one SMA engine among NCH requesting channels.
// Grants one channel at a time, launches an engine update, and returns the average or times out.
module sma_sched #(
    parameter int unsigned NCH     = 4,
    parameter int unsigned W       = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    sysrst,
    input  logic [NCH-1:0]          req,
    input  logic [NCH*W-1:0]        din,
    output logic [NCH-1:0]          ack,
    output logic [W-1:0]            eng_din,
    output logic [$clog2(NCH)-1:0]  eng_sel,
    output logic                    eng_start,
    input  logic                    eng_done,
    input  logic [W-1:0]            eng_avg,
    output logic [W-1:0]            avg,
    output logic [NCH-1:0]          avg_valid,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr
);

    localparam int unsigned SW = $clog2(NCH);
    localparam int unsigned TW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

    state_t          state, state_n;
    logic [SW-1:0]   ptr, ptr_n;
    logic [TW-1:0]   timer, timer_n;
    logic [SW-1:0]   sel_n;
    logic [W-1:0]    din_n;
    logic [NCH-1:0]  ack_n;
    logic            start_n;
    logic [W-1:0]    avg_n;
    logic [NCH-1:0]  av_n;
    logic            busy_n;
    logic            err_n;

    logic [W-1:0]    lane [NCH];
    logic            found;
    logic [SW-1:0]   win;
    logic [SW:0]     pos;
    logic [SW-1:0]   g_inc;

    for (genvar i = 0; i < NCH; i++) begin : g_lane
        assign lane[i] = din[i*W +: W];
    end

    // Rotating-priority search starting at ptr; pos is one bit wider so the wrap needs no modulo.
    always_comb begin
        found = 1'b0;
        win   = '0;
        pos   = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            pos = {1'b0, ptr} + (SW+1)'(k);
            if (pos >= (SW+1)'(NCH))
                pos = pos - (SW+1)'(NCH);
            if (!found && req[SW'(pos)]) begin
                found = 1'b1;
                win   = SW'(pos);
            end
        end
    end

    // eng_sel doubles as the latched grant g: it is loaded on the same edge that enters START.
    assign g_inc = (eng_sel == SW'(NCH-1)) ? '0 : eng_sel + SW'(1);

    always_comb begin
        state_n = state;
        ptr_n   = ptr;
        timer_n = timer;
        sel_n   = eng_sel;
        din_n   = eng_din;
        ack_n   = '0;
        start_n = 1'b0;
        avg_n   = avg;
        av_n    = '0;
        err_n   = err_clr ? 1'b0 : err;
        case (state)
            IDLE: begin
                if (found) begin
                    sel_n      = win;
                    din_n      = lane[win];
                    ack_n[win] = 1'b1;
                    start_n    = 1'b1;
                    state_n    = START;
                end
            end
            START: begin
                timer_n = '0;
                state_n = WAIT;
            end
            WAIT: begin
                if (eng_done) begin
                    avg_n         = eng_avg;
                    av_n[eng_sel] = 1'b1;
                    ptr_n         = g_inc;
                    state_n       = IDLE;
                end else if (timer == TW'(TIMEOUT-1)) begin
                    err_n   = 1'b1;
                    ptr_n   = g_inc;
                    state_n = IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n != IDLE);
    end

    always_ff @(posedge clk) begin
        if (sysrst) begin
            state     <= IDLE;
            ptr       <= '0;
            timer     <= '0;
            eng_sel   <= '0;
            eng_din   <= '0;
            ack       <= '0;
            eng_start <= 1'b0;
            avg       <= '0;
            avg_valid <= '0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            timer     <= timer_n;
            eng_sel   <= sel_n;
            eng_din   <= din_n;
            ack       <= ack_n;
            eng_start <= start_n;
            avg       <= avg_n;
            avg_valid <= av_n;
            busy      <= busy_n;
            err       <= err_n;
        end
    end

endmodule

// File: doc/sma_sched.md
SMA_SCHED -- requirements
Module: sma_sched

Interface
REQ-001 Parameter NCH, 4, number of requesting channels (2..8).
REQ-002 Parameter W, 16, sample and average width.
REQ-003 Parameter TIMEOUT, 64, maximum WAIT cycles before abort (≥2).
REQ-004 clk  in  1  sole clock; all logic on rising edge.
REQ-005 sysrst  in  1  reset, synchronous, active-high.
REQ-006 req  in  NCH  per-channel sample request; level, held until ack.
REQ-007 din  in  NCH*W  packed samples; channel i at bits [i*W +: W].
REQ-008 ack  out  NCH  one-cycle pulse: channel's sample accepted.
REQ-009 eng_din  out  W  sample presented to the shared SMA engine.
REQ-010 eng_sel  out  clog2(NCH)  channel id; engine keeps per-channel history.
REQ-011 eng_start  out  1  one-cycle pulse launching one engine update.
REQ-012 eng_done  in  1  engine result-ready pulse.
REQ-013 eng_avg  in  W  engine average, valid with eng_done.
REQ-014 avg  out  W  last completed average.
REQ-015 avg_valid  out  NCH  one-cycle pulse on owning channel's bit when avg updates.
REQ-016 busy  out  1  high whenever state is not IDLE.
REQ-017 err  out  1  sticky timeout flag.
REQ-018 err_clr  in  1  clears err.

Function
REQ-019 FSM states SHALL be IDLE, START, WAIT; all outputs registered.
REQ-020 IDLE: when req nonzero, the winner is the first set req bit at or above rr pointer ptr, wrapping modulo NCH; SHALL latch g, din[g], go START.
REQ-021 IDLE with req all zero: SHALL stay IDLE, no outputs pulsed.
REQ-022 START (one cycle): ack[g]=1, eng_start=1, eng_sel=g, eng_din=latched sample; then WAIT with timer cleared.
REQ-023 eng_sel and eng_din SHALL hold their values from START until the next START.
REQ-024 WAIT: timer increments each cycle; eng_done=1 SHALL load avg<=eng_avg, pulse avg_valid[g] next cycle, set ptr<=(g+1) mod NCH, go IDLE.
REQ-025 WAIT: timer reaching TIMEOUT-1 without eng_done SHALL set err, set ptr<=(g+1) mod NCH, go IDLE, no avg_valid, avg unchanged.
REQ-026 eng_done and timer expiry in the same cycle: done SHALL win, no err.
REQ-027 eng_done in IDLE or START SHALL be ignored.
REQ-028 Latency: req seen in IDLE at cycle t -> ack and eng_start at t+1; eng_done at cycle d -> avg_valid at d+1, IDLE at d+1, next eng_start no earlier than d+2.
REQ-029 A request deasserted before ack SHALL be treated as withdrawn; no ack issued for it unless re-granted.
REQ-030 err_clr SHALL clear err next cycle; err_clr with a same-cycle timeout SHALL leave err set.
REQ-031 At most one ack bit and one avg_valid bit SHALL be high in any cycle.
REQ-032 Channel indices SHALL wrap: g=NCH-1 gives ptr=0.

Reset
REQ-033 sysrst high SHALL force IDLE, ptr=0, g=0, timer=0, ack=0, eng_start=0, eng_din=0, eng_sel=0, avg=0, avg_valid=0, busy=0, err=0 at the next edge.
REQ-034 sysrst mid-WAIT SHALL abandon the transaction without avg_valid or err; a later eng_done SHALL be ignored.
REQ-035 sysrst overrides err_clr and all other inputs.

Verification
REQ-036 Single request: req=0001, din[0]=0x0123, engine returns 0x0040 three cycles after start -> ack=0001 and eng_start with eng_din=0x0123, eng_sel=0; avg=0x0040, avg_valid=0001 one cycle after eng_done.
REQ-037 Round robin: req=1111 held and re-raised after each ack, engine 2-cycle latency -> grant order 0,1,2,3,0; no channel granted twice in a row.
REQ-038 Wrap: ptr=3, req=0011 -> channel 0 granted, then channel 1.
REQ-039 Timeout: engine silent, TIMEOUT=64 -> err=1 at WAIT cycle 64, no avg_valid, busy drops, next request served; err_clr -> err=0.
REQ-040 Done and expiry same cycle -> avg_valid pulses, err stays 0.
REQ-041 Reset in WAIT then stale eng_done -> all outputs zero, no avg_valid, state IDLE.
